// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the decoder.
// Holds the loader FSM state encodings, the halt word / opcode constants
// and the default address and data widths.
package instr_mem_loader_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 16;

    // Opcodes live in the top nibble of an instruction word.
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [15:0] HALT_WORD_DEF = {OP_HALT, 12'h000};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_HI = 3'd1,
        LOAD_LO = 3'd2,
        DONE    = 3'd3,
        RUN     = 3'd4
    } ld_state_e;

endpackage

// File: rtl/instr_mem_loader_ram.sv
// Single-port synchronous RAM holding the instruction image.
// Ports: clk, we (write enable), addr (shared read/write address),
//        wdata (write data), rdata (registered read data, one-cycle latency).
// Contents are never cleared, so the array maps onto block RAM.
module instr_ram
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory responder with a byte-serial program-load port.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   instr_addr      fetch address; instr is the registered instruction word
//   ld_start        pulse: begin a new load (restarts at address 0)
//   ld_valid/ld_byte/ld_last/ld_ready  byte stream, big-endian 16-bit words
//   ld_done         one-cycle pulse when a load finishes
//   ld_err          sticky: odd byte count or memory overflow
//   prog_len        number of words in the loaded program
//   run_en          core may execute (RUN state only)
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned        ADDR_W    = ADDR_W_DEF,
    parameter int unsigned        DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0]  HALT_WORD = HALT_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic [DATA_W-1:0] instr,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_err,
    output logic [ADDR_W:0]   prog_len,
    output logic              run_en
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    ld_state_e         state_q;
    logic [ADDR_W:0]   ptr_q;
    logic [7:0]        hi_q;
    logic              ld_ready_q;
    logic              ld_done_q;
    logic              ld_err_q;
    logic [ADDR_W:0]   prog_len_q;
    logic              run_en_q;
    logic              rd_ok_q;

    logic              accept;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign accept   = ld_valid && ld_ready_q && !ld_start;
    assign ram_we   = accept && !rst && (state_q == LOAD_LO);
    // Reads happen only in RUN, so the single port is never contended.
    assign ram_addr = (state_q == RUN) ? instr_addr : ptr_q[ADDR_W-1:0];

    instr_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (DATA_W'({hi_q, ld_byte})),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hi_q       <= '0;
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b0;
            ld_err_q   <= 1'b0;
            prog_len_q <= '0;
            run_en_q   <= 1'b0;
            rd_ok_q    <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            // The range check is registered alongside the RAM read so the
            // word and its validity line up one cycle after the address.
            rd_ok_q   <= (state_q == RUN) && ({1'b0, instr_addr} < prog_len_q);

            if (ld_start) begin
                state_q    <= LOAD_HI;
                ptr_q      <= '0;
                ld_err_q   <= 1'b0;
                run_en_q   <= 1'b0;
                ld_ready_q <= 1'b1;
            end else begin
                case (state_q)
                    LOAD_HI: begin
                        if (accept) begin
                            if (ld_last) begin
                                // Odd byte count: drop the dangling high byte.
                                ld_err_q   <= 1'b1;
                                state_q    <= DONE;
                                ld_ready_q <= 1'b0;
                                ld_done_q  <= 1'b1;
                                prog_len_q <= ptr_q;
                            end else begin
                                hi_q    <= ld_byte;
                                state_q <= LOAD_LO;
                            end
                        end
                    end
                    LOAD_LO: begin
                        if (accept) begin
                            ptr_q <= ptr_q + PTR_ONE;
                            if (ld_last || (ptr_q[ADDR_W-1:0] == '1)) begin
                                ld_err_q   <= ld_err_q | !ld_last;
                                state_q    <= DONE;
                                ld_ready_q <= 1'b0;
                                ld_done_q  <= 1'b1;
                                prog_len_q <= ptr_q + PTR_ONE;
                            end else begin
                                state_q <= LOAD_HI;
                            end
                        end
                    end
                    DONE: begin
                        state_q  <= RUN;
                        run_en_q <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign instr    = rd_ok_q ? ram_rdata : HALT_WORD;
    assign ld_ready = ld_ready_q;
    assign ld_done  = ld_done_q;
    assign ld_err   = ld_err_q;
    assign prog_len = prog_len_q;
    assign run_en   = run_en_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] instr_addr;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;

    logic [15:0] instr,    instr4;
    logic        ld_ready, ld_ready4;
    logic        ld_done,  ld_done4;
    logic        ld_err,   ld_err4;
    logic [12:0] prog_len;
    logic [4:0]  prog_len4;
    logic        run_en,   run_en4;

    logic        sel4;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned done_cnt = 0;

    always #5 clk = ~clk;

    instr_mem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .instr_addr (instr_addr),
        .instr      (instr),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .ld_done    (ld_done),
        .ld_err     (ld_err),
        .prog_len   (prog_len),
        .run_en     (run_en)
    );

    instr_mem_loader #(.ADDR_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .instr_addr (instr_addr[3:0]),
        .instr      (instr4),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready4),
        .ld_done    (ld_done4),
        .ld_err     (ld_err4),
        .prog_len   (prog_len4),
        .run_en     (run_en4)
    );

    always @(negedge clk) if (ld_done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic cur_ready();
        return sel4 ? ld_ready4 : ld_ready;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int unsigned n = 0;
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        while (!cur_ready() && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [11:0] a, input logic [15:0] exp);
        instr_addr = a;
        tick();
        check(tag, sel4 ? instr4 : instr, exp);
    endtask

    initial begin
        int unsigned d0;
        rst = 1'b1; instr_addr = '0; ld_start = 0; ld_valid = 0;
        ld_byte = '0; ld_last = 0; sel4 = 0;

        // 1: reset
        tick(); tick();
        rst = 1'b0;
        check("rst_instr", instr, 16'hF000);
        check("rst_run_en", run_en, 0);
        check("rst_ready", ld_ready, 0);
        check("rst_prog_len", prog_len, 0);
        fetch("idle_fetch0", 12'd0, 16'hF000);

        // 2: two-word program
        d0 = done_cnt;
        start_load();
        check("t2_ready", ld_ready, 1);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'h56, 0); send_byte(8'h78, 1);
        check("t2_done_hi", ld_done, 1);
        check("t2_ready_done", ld_ready, 0);
        tick();
        check("t2_done_lo", ld_done, 0);
        check("t2_run_en", run_en, 1);
        check("t2_prog_len", prog_len, 2);
        check("t2_done_cnt", done_cnt - d0, 1);
        fetch("t2_a0", 12'd0, 16'h1234);
        fetch("t2_a1", 12'd1, 16'h5678);
        fetch("t2_a2", 12'd2, 16'hF000);

        // 3: odd byte count
        start_load();
        check("t3_run_off", run_en, 0);
        send_byte(8'hAB, 0); send_byte(8'hCD, 0); send_byte(8'hEF, 1);
        tick();
        check("t3_err", ld_err, 1);
        check("t3_prog_len", prog_len, 1);
        fetch("t3_a0", 12'd0, 16'hABCD);
        fetch("t3_a1", 12'd1, 16'hF000);

        // 4: gapped valid, reload mid-load with a colliding byte
        start_load();
        check("t4_err_clr", ld_err, 0);
        send_byte(8'h11, 0); tick();
        send_byte(8'h22, 0); tick();
        send_byte(8'h33, 0); tick();
        ld_valid = 1'b1; ld_byte = 8'h44; ld_start = 1'b1;
        tick();
        ld_valid = 1'b0; ld_start = 1'b0;
        tick();
        send_byte(8'hA1, 0); tick();
        send_byte(8'hB2, 0); tick();
        send_byte(8'hC3, 0); tick();
        send_byte(8'hD4, 0); tick();
        send_byte(8'hE5, 0); tick();
        send_byte(8'hF6, 1);
        tick();
        check("t4_prog_len", prog_len, 3);
        check("t4_err", ld_err, 0);
        fetch("t4_a0", 12'd0, 16'hA1B2);
        fetch("t4_a1", 12'd1, 16'hC3D4);
        fetch("t4_a2", 12'd2, 16'hE5F6);
        fetch("t4_a3", 12'd3, 16'hF000);

        // 5: reset during LOAD_LO after 3 words
        start_load();
        send_byte(8'h01, 0); send_byte(8'h02, 0);
        send_byte(8'h03, 0); send_byte(8'h04, 0);
        send_byte(8'h05, 0); send_byte(8'h06, 0);
        send_byte(8'h07, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_ready", ld_ready, 0);
        check("t5_run_en", run_en, 0);
        check("t5_prog_len", prog_len, 0);
        check("t5_instr", instr, 16'hF000);
        start_load();
        send_byte(8'h9A, 0); send_byte(8'hBC, 1);
        tick();
        check("t5_prog_len1", prog_len, 1);
        fetch("t5_a0", 12'd0, 16'h9ABC);
        fetch("t5_a1", 12'd1, 16'hF000);

        // 6: overflow on the ADDR_W=4 instance
        sel4 = 1'b1;
        start_load();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), 0);
            send_byte(8'(8'hA0 + i), 0);
        end
        check("t6_err", ld_err4, 1);
        check("t6_ready", ld_ready4, 0);
        check("t6_done", ld_done4, 1);
        ld_valid = 1'b1; ld_byte = 8'h77;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t6_no_accept", ld_ready4, 0);
        end
        ld_valid = 1'b0;
        check("t6_prog_len", prog_len4, 16);
        check("t6_run_en", run_en4, 1);
        fetch("t6_a0", 12'd0, 16'h00A0);
        fetch("t6_a15", 12'd15, 16'h0FAF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Instruction-memory responder on the fetch side of the CPU. Answers the fetch stage's 12-bit instruction address with a registered 16-bit instruction word.
- Also owns a byte-serial program-load port, e.g. from a UART or switch bank. The port assembles big-endian 16-bit words and writes them sequentially from address 0.
- Gates the core with run_en until a load completes.

Parameters:
- ADDR_W, 12, instruction address width; depth = 2**ADDR_W words.
- DATA_W, 16, instruction word width; the load port supplies exactly 2 bytes per word.
- HALT_WORD, 16'hF000, word returned for out-of-range or not-running fetches (opcode F = halt).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- instr_addr  in  ADDR_W  fetch address from the fetch stage.
- instr  out  DATA_W  instruction word, registered.
- ld_start  in  1  begin a new program load; single-cycle pulse.
- ld_valid  in  1  ld_byte is valid this cycle.
- ld_byte  in  8  program byte; high byte of each word first.
- ld_last  in  1  qualifies ld_byte as the final byte of the program.
- ld_ready  out  1  loader accepts a byte this cycle.
- ld_done  out  1  one-cycle pulse when a load finishes.
- ld_err  out  1  sticky error: odd byte count or overflow; cleared by ld_start or rst.
- prog_len  out  ADDR_W+1  number of words in the loaded program.
- run_en  out  1  core may execute; high only in RUN.

Behaviour:
- States: IDLE, LOAD_HI, LOAD_LO, DONE, RUN. A byte is accepted only on a cycle where ld_valid && ld_ready.
- Reset values (rst high at a clk edge):
  - state=IDLE; instr=HALT_WORD; ld_ready=0; ld_done=0; ld_err=0; prog_len=0; run_en=0; write pointer=0.
  - Memory contents are NOT cleared.
  - rst mid-load abandons the load; words already written remain in memory.
- ld_start (any state except during rst):
  - next state LOAD_HI; write pointer=0; ld_err=0; run_en=0.
  - ld_start has priority over a simultaneous byte acceptance; that byte is dropped.
- LOAD_HI:
  - ld_ready=1.
  - On accept: capture the byte into the high register, go to LOAD_LO.
  - If ld_last is set on this byte (odd byte count): set ld_err, discard the byte, go to DONE.
- LOAD_LO:
  - ld_ready=1.
  - On accept: write mem[ptr]={hi,byte}, ptr++.
  - If ld_last is set: go to DONE.
  - Else if the write was to address 2**ADDR_W-1 (memory full): set ld_err, go to DONE.
  - Else: go to LOAD_HI.
- DONE:
  - Lasts one cycle. ld_done=1, prog_len=ptr (0..2**ADDR_W), ld_ready=0.
  - Then go to RUN.
- RUN:
  - run_en=1, ld_ready=0.
  - Read latency is one cycle: instr at edge N+1 = mem[instr_addr sampled at edge N] if instr_addr < prog_len, else HALT_WORD.
  - prog_len=0 means every fetch returns HALT_WORD.
- Outside RUN: instr is forced to HALT_WORD on every edge.
- Writes and reads never coincide, because reads occur only in RUN. The memory is a single-port synchronous RAM, inferable as block RAM.
- The write pointer wraps naturally but is never used past the overflow check. prog_len holds its value until the next DONE or rst.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=3'd0, LOAD_HI=3'd1, LOAD_LO=3'd2, DONE=3'd3, RUN=3'd4;
  - HALT_WORD and opcode constants, shared with the decoder;
  - ADDR_W/DATA_W defaults.
- One natural sub-module: instr_ram, a single-port synchronous RAM with params ADDR_W/DATA_W and ports clk, we, addr, wdata, rdata. The top-level module holds the FSM, byte assembly and range check.

Test Plan:
1. rst for 2 cycles → instr=16'hF000, run_en=0, ld_ready=0, prog_len=0; fetch of addr 0 still returns F000.
2. ld_start, then bytes 12,34,56,78(ld_last) → ld_done pulses once, prog_len=2, run_en=1. instr_addr=0 gives instr=16'h1234 one cycle later; addr 1 gives 16'h5678; addr 2 gives 16'hF000.
3. ld_start, then bytes AB,CD,EF(ld_last) → ld_err=1, prog_len=1, mem[0]=16'hABCD, addr 1 returns F000.
4. Load with ld_valid toggling every other cycle, plus a reload mid-load via a second ld_start → second program only; prog_len equals its word count; ld_err=0.
5. Assert rst while in LOAD_LO after 3 words → state IDLE, run_en=0, prog_len=0. A new load of 1 word then reads back correctly.
6. Overflow with ADDR_W=4 override: stream 17 words without ld_last → after the 16th word ld_err=1, prog_len=16, ld_ready=0. The extra bytes are not accepted.
